// File: rtl/fetch_decode.sv
// fetch_decode: front-end stage of the multi-cycle CPU.
// Runs the 4-phase sequencer (fetch, reg read, execute/mem, write back),
// fetches the word at pc over a req/ack handshake and decodes it into
// register-file controls that stay stable until the next fetch completes.
// Optional feature macro: FETCH_DECODE_COND_EXEC_EN (conditional execution
// of the ARM cond field against flags; without it every instruction executes).
// Handshake: imem_req is high for the whole FETCH phase (never during reset);
// the fetch completes on the first rising edge where imem_req and imem_ack
// are both high, and imem_rdata is sampled on that same edge.
module fetch_decode #(
    parameter int REG_SIZE  = 32,
    parameter int ADDR_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_SIZE-1:0]  pc,
    input  logic [3:0]           flags,
    output logic                 imem_req,
    output logic [REG_SIZE-1:0]  imem_addr,
    input  logic                 imem_ack,
    input  logic [REG_SIZE-1:0]  imem_rdata,
    output logic [1:0]           phase,
    output logic [ADDR_SIZE-1:0] select1,
    output logic [ADDR_SIZE-1:0] select2,
    output logic [ADDR_SIZE-1:0] wselect,
    output logic [ADDR_SIZE-1:0] shft_reg,
    output logic [REG_SIZE-1:0]  offset,
    output logic                 we,
    output logic                 from_mem,
    output logic                 mem_we,
    output logic                 undef
);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        REG   = 2'b01,
        EXEC  = 2'b10,
        WB    = 2'b11
    } state_t;

    state_t state, state_next;
    logic   fetch_done;

    logic [REG_SIZE-1:0] instr;
    logic                cond_pass;

    logic [ADDR_SIZE-1:0] d_select1, d_select2, d_wselect, d_shft_reg;
    logic [REG_SIZE-1:0]  d_offset;
    logic                 d_we, d_from_mem, d_mem_we;
    logic [REG_SIZE-1:0]  branch_offset;

    // phase is the state encoding itself, so it doubles as the FSM debug view
    assign phase      = state;
    assign imem_req   = (state == FETCH) && !reset;
    assign imem_addr  = pc;
    assign fetch_done = (state == FETCH) && imem_ack;

    // Branch target ends up PC+8+imm*4 once the register file adds its own +4
    assign branch_offset = {{(REG_SIZE-26){imem_rdata[23]}}, imem_rdata[23:0], 2'b00}
                           + REG_SIZE'(4);

`ifdef FETCH_DECODE_COND_EXEC_EN
    // ARM condition evaluation; cond 0xF is treated as never
    always_comb begin
        cond_pass = 1'b0;
        case (imem_rdata[31:28])
            4'h0: cond_pass = flags[2];
            4'h1: cond_pass = !flags[2];
            4'h2: cond_pass = flags[1];
            4'h3: cond_pass = !flags[1];
            4'h4: cond_pass = flags[3];
            4'h5: cond_pass = !flags[3];
            4'h6: cond_pass = flags[0];
            4'h7: cond_pass = !flags[0];
            4'h8: cond_pass = flags[1] && !flags[2];
            4'h9: cond_pass = !flags[1] || flags[2];
            4'hA: cond_pass = (flags[3] == flags[0]);
            4'hB: cond_pass = (flags[3] != flags[0]);
            4'hC: cond_pass = !flags[2] && (flags[3] == flags[0]);
            4'hD: cond_pass = flags[2] || (flags[3] != flags[0]);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end
`else
    logic unused_flags;
    assign cond_pass    = 1'b1;
    assign unused_flags = ^flags;
`endif

    // Decode the incoming word by class; a failed condition squashes side effects
    always_comb begin
        d_select1  = '0;
        d_select2  = '0;
        d_wselect  = '0;
        d_shft_reg = '0;
        d_offset   = '0;
        d_we       = 1'b0;
        d_from_mem = 1'b0;
        d_mem_we   = 1'b0;
        case (imem_rdata[27:26])
            2'b00: begin
                d_select1  = ADDR_SIZE'(imem_rdata[19:16]);
                d_select2  = ADDR_SIZE'(imem_rdata[3:0]);
                d_wselect  = ADDR_SIZE'(imem_rdata[15:12]);
                d_shft_reg = ADDR_SIZE'(imem_rdata[11:8]);
                // TST/TEQ/CMP/CMN only update flags
                d_we       = (imem_rdata[24:23] != 2'b10);
            end
            2'b01: begin
                d_select1  = ADDR_SIZE'(imem_rdata[19:16]);
                d_select2  = ADDR_SIZE'(imem_rdata[15:12]);
                d_wselect  = ADDR_SIZE'(imem_rdata[15:12]);
                d_we       = imem_rdata[20];
                d_from_mem = imem_rdata[20];
                d_mem_we   = !imem_rdata[20];
            end
            2'b10: begin
                d_offset = branch_offset;
            end
            default: begin
            end
        endcase
        if (!cond_pass) begin
            d_we       = 1'b0;
            d_from_mem = 1'b0;
            d_mem_we   = 1'b0;
            d_offset   = '0;
        end
    end

    // Sequencer next state: only FETCH waits, on the instruction ack
    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (imem_ack) state_next = REG;
            REG:     state_next = EXEC;
            EXEC:    state_next = WB;
            default: state_next = FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Latch the instruction and its decode on the completing fetch edge
    always_ff @(posedge clk) begin
        if (reset) begin
            instr    <= '0;
            select1  <= '0;
            select2  <= '0;
            wselect  <= '0;
            shft_reg <= '0;
            offset   <= '0;
            we       <= 1'b0;
            from_mem <= 1'b0;
            mem_we   <= 1'b0;
        end else if (fetch_done) begin
            instr    <= imem_rdata;
            select1  <= d_select1;
            select2  <= d_select2;
            wselect  <= d_wselect;
            shft_reg <= d_shft_reg;
            offset   <= d_offset;
            we       <= d_we;
            from_mem <= d_from_mem;
            mem_we   <= d_mem_we;
        end
    end

    // Undefined class is flagged for exactly the REG cycle
    assign undef = (state == REG) && (instr[27:26] == 2'b11);

    logic unused_instr;
    assign unused_instr = ^{instr[REG_SIZE-1:28], instr[25:0]};

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode. Expected decode comes from a
// behavioural model of the instruction classes and ARM condition codes.
// Expectations follow FETCH_DECODE_COND_EXEC_EN when it is defined.
module tb_fetch_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [3:0]  flags;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [1:0]  phase;
    logic [4:0]  select1, select2, wselect, shft_reg;
    logic [31:0] offset;
    logic        we, from_mem, mem_we, undef;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [4:0]  ws;
        logic [4:0]  sh;
        logic [31:0] off;
        logic        we;
        logic        fm;
        logic        mw;
    } dec_t;

    dec_t dut_dec;
    assign dut_dec = {select1, select2, wselect, shft_reg, offset, we, from_mem, mem_we};

    fetch_decode dut (
        .clk(clk), .reset(reset), .pc(pc), .flags(flags),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .phase(phase), .select1(select1), .select2(select2),
        .wselect(wselect), .shft_reg(shft_reg), .offset(offset),
        .we(we), .from_mem(from_mem), .mem_we(mem_we), .undef(undef)
    );

    // clock / reset block
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cc, v;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
`ifdef FETCH_DECODE_COND_EXEC_EN
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cc;
            4'h3: return !cc;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cc && !z;
            4'h9: return !cc || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
`else
        return (c == c) && (f == f);
`endif
    endfunction

    function automatic dec_t model(input logic [31:0] ins, input logic [3:0] f);
        dec_t e;
        int   cls, rn, rd, rs, rm, opc;
        longint imm;
        e   = '0;
        cls = int'(ins[27:26]);
        rn  = int'(ins[19:16]); rd = int'(ins[15:12]);
        rs  = int'(ins[11:8]);  rm = int'(ins[3:0]);
        opc = int'(ins[24:21]);
        if (cls == 0) begin
            e.s1 = 5'(rn); e.s2 = 5'(rm); e.ws = 5'(rd); e.sh = 5'(rs);
            e.we = !(opc >= 8 && opc <= 11);
        end else if (cls == 1) begin
            e.s1 = 5'(rn); e.s2 = 5'(rd); e.ws = 5'(rd);
            e.we = ins[20]; e.fm = ins[20]; e.mw = !ins[20];
        end else if (cls == 2) begin
            imm = longint'(ins[23:0]);
            if (imm >= 64'd8388608) imm = imm - 64'd16777216;
            e.off = 32'(imm * 4 + 4);
        end
        if (!cond_ok(ins[31:28], f)) begin
            e.we = 0; e.fm = 0; e.mw = 0; e.off = 0;
        end
        return e;
    endfunction

    // driver: one full instruction, ack after 'delay' extra FETCH cycles
    task automatic run_instr(input logic [31:0] ins, input int delay,
                             input logic [3:0] f, output int cycles);
        dec_t e;
        bit   exp_undef;
        e = model(ins, f);
        exp_undef = (ins[27:26] == 2'b11);
        pc = $urandom; flags = f; imem_ack = 0; imem_rdata = $urandom;
        #1;
        cycles = 0;
        checks++;
        if (phase !== 2'b00 || imem_req !== 1'b1 || imem_addr !== pc) begin
            failures++;
            $display("FAIL fetch_req: phase=%0d req=%0b addr=%h expected phase=0 req=1 addr=%h",
                     phase, imem_req, imem_addr, pc);
        end
        for (int i = 0; i < delay; i++) begin
            tick(); cycles++;
            checks++;
            if (phase !== 2'b00 || imem_req !== 1'b1) begin
                failures++;
                $display("FAIL fetch_wait: phase=%0d req=%0b expected phase=0 req=1", phase, imem_req);
            end
        end
        imem_ack = 1; imem_rdata = ins;
        tick(); cycles++;
        imem_ack = 1'($urandom); imem_rdata = $urandom;
        checks++;
        if (phase !== 2'b01 || imem_req !== 1'b0 || dut_dec !== e || undef !== exp_undef) begin
            failures++;
            $display("FAIL reg_decode ins=%h: phase=%0d req=%0b dec=%h undef=%0b expected phase=1 req=0 dec=%h undef=%0b",
                     ins, phase, imem_req, dut_dec, undef, e, exp_undef);
        end
        tick(); cycles++;
        imem_ack = 1'($urandom);
        checks++;
        if (phase !== 2'b10 || dut_dec !== e || undef !== 1'b0) begin
            failures++;
            $display("FAIL exec_stable ins=%h: phase=%0d dec=%h undef=%0b expected phase=2 dec=%h undef=0",
                     ins, phase, dut_dec, undef, e);
        end
        tick(); cycles++;
        imem_ack = 1'($urandom);
        checks++;
        if (phase !== 2'b11 || dut_dec !== e) begin
            failures++;
            $display("FAIL wb_stable ins=%h: phase=%0d dec=%h expected phase=3 dec=%h", ins, phase, dut_dec, e);
        end
        tick(); cycles++;
        imem_ack = 0;
        checks++;
        if (phase !== 2'b00 || dut_dec !== e) begin
            failures++;
            $display("FAIL back_to_fetch ins=%h: phase=%0d dec=%h expected phase=0 dec=%h", ins, phase, dut_dec, e);
        end
    endtask

    task automatic test_reset();
        reset = 1; imem_ack = 0; imem_rdata = 0; pc = 0; flags = 0;
        tick(); tick();
        reset = 0;
        #1;
        checks++;
        if (phase !== 2'b00 || imem_req !== 1'b1 || dut_dec !== '0 || undef !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: phase=%0d req=%0b dec=%h undef=%0b expected 0 1 0 0",
                     phase, imem_req, dut_dec, undef);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (phase !== 2'b00 || imem_req !== 1'b1) begin
                failures++;
                $display("FAIL reset_hold: phase=%0d req=%0b expected phase=0 req=1", phase, imem_req);
            end
        end
    endtask

    task automatic test_alu();
        int cyc;
        run_instr(32'hE0821003, 0, 4'($urandom), cyc);
        checks++;
        if (cyc !== 4 || select1 !== 5'd2 || select2 !== 5'd3 || wselect !== 5'd1 ||
            we !== 1'b1 || offset !== 32'd0) begin
            failures++;
            $display("FAIL alu_add: cyc=%0d s1=%0d s2=%0d ws=%0d we=%0b off=%h expected 4 2 3 1 1 0",
                     cyc, select1, select2, wselect, we, offset);
        end
    endtask

    task automatic test_load_store();
        int cyc;
        run_instr(32'hE5954000, 0, 4'($urandom), cyc);
        checks++;
        if (select1 !== 5'd5 || wselect !== 5'd4 || we !== 1'b1 || from_mem !== 1'b1 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL ldr: s1=%0d ws=%0d we=%0b fm=%0b mw=%0b expected 5 4 1 1 0",
                     select1, wselect, we, from_mem, mem_we);
        end
        run_instr(32'hE5854000, 1, 4'($urandom), cyc);
        checks++;
        if (we !== 1'b0 || from_mem !== 1'b0 || mem_we !== 1'b1 || select2 !== 5'd4) begin
            failures++;
            $display("FAIL str: we=%0b fm=%0b mw=%0b s2=%0d expected 0 0 1 4", we, from_mem, mem_we, select2);
        end
        run_instr(32'hE1510002, 0, 4'($urandom), cyc);
        checks++;
        if (we !== 1'b0) begin
            failures++;
            $display("FAIL cmp_we: we=%0b expected 0", we);
        end
    endtask

    task automatic test_branch();
        int cyc;
        run_instr(32'hEAFFFFFE, 0, 4'($urandom), cyc);
        checks++;
        if (offset !== 32'hFFFFFFFC || we !== 1'b0) begin
            failures++;
            $display("FAIL branch_self: off=%h we=%0b expected FFFFFFFC 0", offset, we);
        end
        run_instr(32'hEA7FFFFF, 0, 4'($urandom), cyc);
        checks++;
        if (offset !== 32'h02000000) begin
            failures++;
            $display("FAIL branch_max: off=%h expected 02000000", offset);
        end
    endtask

    task automatic test_cond();
        int cyc;
        run_instr(32'h00821003, 0, 4'b0000, cyc);
        checks++;
`ifdef FETCH_DECODE_COND_EXEC_EN
        if (we !== 1'b0 || offset !== 32'd0) begin
            failures++;
            $display("FAIL cond_eq_fail: we=%0b off=%h expected 0 0", we, offset);
        end
`else
        if (we !== 1'b1 || offset !== 32'd0) begin
            failures++;
            $display("FAIL cond_ignored: we=%0b off=%h expected 1 0", we, offset);
        end
`endif
        run_instr(32'hEC000000, 2, 4'($urandom), cyc);
    endtask

    task automatic test_random();
        int cyc, d;
        for (int i = 0; i < 60; i++) begin
            d = $urandom_range(0, 3);
            run_instr($urandom, d, 4'($urandom), cyc);
            checks++;
            if (cyc !== d + 4) begin
                failures++;
                $display("FAIL rand_latency: cycles=%0d expected %0d", cyc, d + 4);
            end
        end
    endtask

    task automatic test_latency_reset();
        int cyc;
        run_instr(32'hE0821003, 3, 4'($urandom), cyc);
        checks++;
        if (cyc !== 7) begin
            failures++;
            $display("FAIL late_ack_latency: cycles=%0d expected 7", cyc);
        end
        imem_ack = 1; imem_rdata = 32'hE5954000;
        tick();
        checks++;
        if (phase !== 2'b01) begin
            failures++;
            $display("FAIL pre_reset_reg: phase=%0d expected 1", phase);
        end
        reset = 1;
        tick();
        checks++;
        if (phase !== 2'b00 || imem_req !== 1'b0 || dut_dec !== '0 || undef !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: phase=%0d req=%0b dec=%h undef=%0b expected 0 0 0 0",
                     phase, imem_req, dut_dec, undef);
        end
        reset = 0; imem_ack = 0;
        tick();
        checks++;
        if (phase !== 2'b00 || imem_req !== 1'b1 || dut_dec !== '0) begin
            failures++;
            $display("FAIL after_reset: phase=%0d req=%0b dec=%h expected 0 1 0", phase, imem_req, dut_dec);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_cond();
        test_latency_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // overall time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Front-end stage of the multi-cycle CPU. It owns the 4-phase sequencer (fetch, reg read, execute/mem, write back) and fetches the instruction at `pc` over a req/ack instruction-memory handshake. It decodes the ARM-style instruction word into the register-file controls (read selects, write select, shift register, write enables, branch offset). It sits directly upstream of the register file and drives that file's `phase` and control inputs.

## Interface
- `REG_SIZE`, 32, datapath and instruction width
- `ADDR_SIZE`, 5, register select width; 4-bit ARM fields are zero-extended
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `pc`  in  REG_SIZE  current program counter (r15) from the register file
- `flags`  in  4  NZCV, stable outside the execute phase
- `imem_req`  out  1  instruction fetch request
- `imem_addr`  out  REG_SIZE  fetch address, equals `pc`
- `imem_ack`  in  1  fetch complete; `imem_rdata` valid this cycle
- `imem_rdata`  in  REG_SIZE  instruction word
- `phase`  out  2  00 fetch, 01 reg read, 10 execute/mem, 11 write back
- `select1`, `select2`, `wselect`, `shft_reg`  out  ADDR_SIZE  register selects
- `offset`  out  REG_SIZE  signed PC adjustment applied in write back
- `we`, `from_mem`, `mem_we`  out  1  reg write, load source, store enable
- `undef`  out  1  one-cycle pulse when an undefined class is decoded

## Operation
- FSM states: FETCH(00) → REG(01) → EXEC(10) → WB(11) → FETCH. `phase` equals the state encoding.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc` (combinational). `imem_req` is forced 0 while `reset` is high.
  - The state holds until `imem_ack`=1 is sampled.
  - On the ack edge: latch `imem_rdata`, register all decoded outputs, move to REG.
- REG, EXEC, WB take exactly one cycle each. `imem_ack` outside FETCH is ignored.
- Decoded outputs stay stable from the ack edge until the next ack edge.
- Decode by `instr[27:26]`:
  - 00 data-proc: `select1`=Rn[19:16], `select2`=Rm[3:0], `wselect`=Rd[15:12], `shft_reg`=Rs[11:8]. `we`=1 except opcode 10xx (TST/TEQ/CMP/CMN) → `we`=0. `from_mem`=0, `mem_we`=0, `offset`=0.
  - 01 load/store: `select1`=Rn, `select2`=Rd, `wselect`=Rd, L=`instr[20]`. `we`=L, `from_mem`=L, `mem_we`=~L, `offset`=0.
  - 10 branch: `offset` = sign-extend(imm24)<<2, plus 4, giving target PC+8+imm·4 after the register file's +4. `we`=0, `mem_we`=0. The link bit is ignored.
  - 11 undefined: NOP (`we`=`mem_we`=0, `offset`=0). `undef` pulses during REG.
- Condition (cond=`instr[31:28]`) is evaluated against `flags` at the ack edge using standard ARM codes 0x0–0xE; 0xF is treated as never.
  - On failure: `we`=`mem_we`=`from_mem`=0, `offset`=0. Selects still decode.
- Arithmetic: `offset` is 32-bit two's complement, and the +4 wraps modulo 2^32.

## Timing
- Reset values: state FETCH, `phase`=00, all decoded outputs 0, `undef`=0, latched instruction 0.
- Reset mid-operation: the next cycle is in FETCH and any in-flight ack is discarded.
- Instruction latency: 4 cycles minimum, plus N cycles when the ack arrives N cycles late.
- Ack in the first FETCH cycle → REG on the next cycle.
- `imem_req` deasserts in the cycle after the ack (state is REG).
- `pc` must update only in WB; `imem_addr` tracks it combinationally.

## Configuration
- `FETCH_DECODE_COND_EXEC_EN`:
  - Defined: conditional execution as described above.
  - Undefined: every instruction executes regardless of cond, `flags` is unused, and cond 0xF decodes like 0xE.

## Test plan
- Reset for 2 cycles, then release, with `imem_ack`=0 → `phase`=00, `imem_req`=1, all decoded outputs 0; `phase` holds 00 indefinitely.
- Fetch 0xE0821003 (ADD r1,r2,r3), ack immediately → `phase` 01,10,11,00 on successive cycles; `select1`=2, `select2`=3, `wselect`=1, `we`=1, `offset`=0.
- Fetch 0xE5954000 (LDR r4,[r5]) → `select1`=5, `wselect`=4, `we`=1, `from_mem`=1, `mem_we`=0. Fetch 0xE1510002 (CMP) → `we`=0.
- Fetch 0xEAFFFFFE (B .) → `offset`=0xFFFFFFFC, `we`=0.
- Fetch 0x00821003 with `flags`=0000, macro defined → `we`=0, `offset`=0. With macro undefined → `we`=1.
- Ack delayed 3 cycles, with `reset` pulsed during REG of the following instruction → the first instruction takes 7 cycles; after reset, `phase`=00 and outputs are 0.
